// File: rtl/hyper_rx_pkg.sv
// Shared types and sizing helpers for the HyperBus/xSPI read-capture packer.
// The config struct uses fixed container widths so it is independent of CNT_W/NUM_CH.
package hyper_rx_pkg;

    typedef enum logic [1:0] {
        SKIP = 2'd0,
        PACK = 2'd1,
        DONE = 2'd2
    } hyper_rx_state_e;

    localparam int CFG_SEL_W = 8;
    localparam int CFG_CNT_W = 32;

    typedef struct packed {
        logic                 all_ch;
        logic [CFG_SEL_W-1:0] ch_sel;
        logic [CFG_CNT_W-1:0] skip;
        logic [CFG_CNT_W-1:0] pairs;
    } hyper_rx_cfg_t;

    // Pairs per packed word: one lane gives 2*dq_w bits per pair, all lanes give num_ch times that.
    function automatic int pack_ratio(input logic all_ch, input int out_w, input int dq_w,
                                      input int num_ch);
        return all_ch ? (out_w / (2 * dq_w * num_ch)) : (out_w / (2 * dq_w));
    endfunction

    function automatic int slot_w(input logic all_ch, input int out_w, input int dq_w,
                                  input int num_ch);
        return out_w / pack_ratio(all_ch, out_w, dq_w, num_ch);
    endfunction

endpackage

// File: rtl/hyper_rx_lane_sel.sv
// Combinational lane mux: picks one device lane (zero-extended) or passes all lanes through.
module hyper_rx_lane_sel
    import hyper_rx_pkg::*;
#(
    parameter int DQ_W   = 8,
    parameter int NUM_CH = 2,
    localparam int LANE_W = 2 * DQ_W,
    localparam int PAIR_W = 2 * DQ_W * NUM_CH
) (
    input  logic                 i_all_ch,
    input  logic [CFG_SEL_W-1:0] i_ch_sel,
    input  logic [PAIR_W-1:0]    i_pair,
    output logic [PAIR_W-1:0]    o_slot
);

    always_comb begin
        o_slot = '0;
        if (i_all_ch) begin
            o_slot = i_pair;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (i_ch_sel == CFG_SEL_W'(k))
                    o_slot[LANE_W-1:0] = i_pair[k*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/hyper_rx_pack_ctrl.sv
// Read-capture packer on the RWDS clock: skips leading pairs, packs pairs into words, flags overflow.
// Optional debug outputs err_extra_o / pair_cnt_o are built when HYPER_RX_ERR_EN is defined.
module hyper_rx_pack_ctrl
    import hyper_rx_pkg::*;
#(
    parameter int DQ_W   = 8,
    parameter int NUM_CH = 2,
    parameter int OUT_W  = 32,
    parameter int CNT_W  = 16,
    localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PAIR_W = 2 * DQ_W * NUM_CH
) (
    input  logic                 clk_rwds,
    input  logic                 resetReadModule,
    input  logic                 cfg_all_ch_i,
    input  logic [SEL_W-1:0]     cfg_ch_sel_i,
    input  logic [CNT_W-1:0]     cfg_skip_i,
    input  logic [CNT_W-1:0]     cfg_pairs_i,
    input  logic                 ddr_valid_i,
    input  logic [PAIR_W-1:0]    ddr_pair_i,
    input  logic                 fifo_ready_i,
    output logic                 valid_o,
    output logic [OUT_W-1:0]     word_o,
    output logic [OUT_W/8-1:0]   strb_o,
    output logic                 last_o,
    output logic                 overflow_o,
    output logic                 done_o
`ifdef HYPER_RX_ERR_EN
    ,
    output logic                 err_extra_o,
    output logic [CNT_W-1:0]     pair_cnt_o
`endif
);

    localparam int MAX_PACK = OUT_W / (2 * DQ_W);
    localparam int IDX_W    = (MAX_PACK > 1) ? $clog2(MAX_PACK) : 1;
    localparam int STRB_W   = OUT_W / 8;

    hyper_rx_cfg_t   w_cfg;
    hyper_rx_state_e r_state, w_state_nxt;

    logic [IDX_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_skip_cnt, r_pair_cnt;
    logic [OUT_W-1:0]  r_word, w_word_nxt;
    logic [STRB_W-1:0] r_strb, w_strb_nxt;
    logic [PAIR_W-1:0] w_slot;

    logic              r_valid, r_last, r_overflow;
    logic [OUT_W-1:0]  r_word_out;
    logic [STRB_W-1:0] r_strb_out;

    logic w_skip_pend, w_pair_last, w_idx_full;
    logic w_skip_inc, w_take, w_emit, w_last;
    int   w_pack, w_slot_w, w_slot_b;

    // Config is quasi-static, so it is used directly without a capture stage.
    always_comb begin
        w_cfg.all_ch = cfg_all_ch_i;
        w_cfg.ch_sel = CFG_SEL_W'(cfg_ch_sel_i);
        w_cfg.skip   = CFG_CNT_W'(cfg_skip_i);
        w_cfg.pairs  = CFG_CNT_W'(cfg_pairs_i);
    end

    hyper_rx_lane_sel #(
        .DQ_W   (DQ_W),
        .NUM_CH (NUM_CH)
    ) u_lane_sel (
        .i_all_ch (w_cfg.all_ch),
        .i_ch_sel (w_cfg.ch_sel),
        .i_pair   (ddr_pair_i),
        .o_slot   (w_slot)
    );

    always_comb begin
        w_pack      = pack_ratio(w_cfg.all_ch, OUT_W, DQ_W, NUM_CH);
        w_slot_w    = slot_w(w_cfg.all_ch, OUT_W, DQ_W, NUM_CH);
        w_slot_b    = w_slot_w / 8;
        w_skip_pend = CFG_CNT_W'(r_skip_cnt) < w_cfg.skip;
        w_pair_last = (CFG_CNT_W'(r_pair_cnt) + CFG_CNT_W'(1)) == w_cfg.pairs;
        w_idx_full  = (int'(r_idx) == (w_pack - 1));
        // Unfilled slots are always zero, so OR-ing in the new slot is enough.
        w_word_nxt  = r_word | (OUT_W'(w_slot) << (int'(r_idx) * w_slot_w));
        w_strb_nxt  = r_strb;
        for (int b = 0; b < STRB_W; b++) begin
            if ((b >= int'(r_idx) * w_slot_b) && (b < (int'(r_idx) + 1) * w_slot_b))
                w_strb_nxt[b] = 1'b1;
        end
    end

    always_ff @(posedge clk_rwds or posedge resetReadModule) begin
        if (resetReadModule) r_state <= SKIP;
        else                 r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_skip_inc  = 1'b0;
        w_take      = 1'b0;
        w_emit      = 1'b0;
        w_last      = 1'b0;
        if (ddr_valid_i) begin
            case (r_state)
                SKIP: begin
                    if (w_skip_pend) begin
                        w_skip_inc = 1'b1;
                    end else if (w_cfg.pairs == '0) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_take      = 1'b1;
                        w_state_nxt = PACK;
                    end
                end
                PACK:    w_take = 1'b1;
                DONE:    w_take = 1'b0;
                default: w_state_nxt = SKIP;
            endcase
        end
        if (w_take) begin
            w_last = w_pair_last;
            w_emit = w_idx_full || w_pair_last;
            if (w_pair_last) w_state_nxt = DONE;
        end
    end

    always_ff @(posedge clk_rwds or posedge resetReadModule) begin
        if (resetReadModule) begin
            r_idx      <= '0;
            r_skip_cnt <= '0;
            r_pair_cnt <= '0;
            r_word     <= '0;
            r_strb     <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_overflow <= 1'b0;
            r_word_out <= '0;
            r_strb_out <= '0;
        end else begin
            r_valid <= w_emit;
            r_last  <= w_emit & w_last;
            // RWDS cannot be stalled: the word is presented regardless, only the error is recorded.
            if (r_valid && !fifo_ready_i) r_overflow <= 1'b1;
            if (w_skip_inc) r_skip_cnt <= r_skip_cnt + CNT_W'(1);
            if (w_take) begin
                r_pair_cnt <= r_pair_cnt + CNT_W'(1);
                if (w_emit) begin
                    r_word_out <= w_word_nxt;
                    r_strb_out <= w_strb_nxt;
                    r_word     <= '0;
                    r_strb     <= '0;
                    r_idx      <= '0;
                end else begin
                    r_word     <= w_word_nxt;
                    r_strb     <= w_strb_nxt;
                    r_idx      <= r_idx + IDX_W'(1);
                end
            end
        end
    end

    assign valid_o    = r_valid;
    assign word_o     = r_word_out;
    assign strb_o     = r_strb_out;
    assign last_o     = r_last;
    assign overflow_o = r_overflow;
    assign done_o     = (r_state == DONE);

`ifdef HYPER_RX_ERR_EN
    logic             r_err_extra;
    logic [CNT_W-1:0] r_rx_cnt;

    always_ff @(posedge clk_rwds or posedge resetReadModule) begin
        if (resetReadModule) begin
            r_err_extra <= 1'b0;
            r_rx_cnt    <= '0;
        end else if (ddr_valid_i) begin
            if (r_state == DONE) r_err_extra <= 1'b1;
            if (r_rx_cnt != '1)  r_rx_cnt    <= r_rx_cnt + CNT_W'(1);
        end
    end

    assign err_extra_o = r_err_extra;
    assign pair_cnt_o  = r_rx_cnt;
`endif

endmodule

// File: tb/tb_hyper_rx_pack_ctrl.sv
// Directed bench for hyper_rx_pack_ctrl: hand-computed words, strobes, last, overflow and reset cases.
module tb_hyper_rx_pack_ctrl;

    localparam int DQ_W   = 8;
    localparam int NUM_CH = 2;
    localparam int OUT_W  = 32;
    localparam int CNT_W  = 16;

    logic              clk_rwds = 1'b0;
    logic              resetReadModule;
    logic              cfg_all_ch_i;
    logic [0:0]        cfg_ch_sel_i;
    logic [CNT_W-1:0]  cfg_skip_i;
    logic [CNT_W-1:0]  cfg_pairs_i;
    logic              ddr_valid_i;
    logic [31:0]       ddr_pair_i;
    logic              fifo_ready_i;
    logic              valid_o;
    logic [OUT_W-1:0]  word_o;
    logic [3:0]        strb_o;
    logic              last_o;
    logic              overflow_o;
    logic              done_o;
`ifdef HYPER_RX_ERR_EN
    logic              err_extra_o;
    logic [CNT_W-1:0]  pair_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk_rwds = ~clk_rwds;

    hyper_rx_pack_ctrl #(
        .DQ_W   (DQ_W),
        .NUM_CH (NUM_CH),
        .OUT_W  (OUT_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_rwds        (clk_rwds),
        .resetReadModule (resetReadModule),
        .cfg_all_ch_i    (cfg_all_ch_i),
        .cfg_ch_sel_i    (cfg_ch_sel_i),
        .cfg_skip_i      (cfg_skip_i),
        .cfg_pairs_i     (cfg_pairs_i),
        .ddr_valid_i     (ddr_valid_i),
        .ddr_pair_i      (ddr_pair_i),
        .fifo_ready_i    (fifo_ready_i),
        .valid_o         (valid_o),
        .word_o          (word_o),
        .strb_o          (strb_o),
        .last_o          (last_o),
        .overflow_o      (overflow_o),
        .done_o          (done_o)
`ifdef HYPER_RX_ERR_EN
        ,
        .err_extra_o     (err_extra_o),
        .pair_cnt_o      (pair_cnt_o)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one edge's worth of input on the falling edge; registered outputs seen here come from the previous rise.
    task automatic step(input logic v, input logic [31:0] p);
        @(negedge clk_rwds);
        ddr_valid_i = v;
        ddr_pair_i  = p;
    endtask

    task automatic do_reset(input logic all_ch, input logic sel, input int skip, input int pairs);
        @(negedge clk_rwds);
        resetReadModule = 1'b1;
        ddr_valid_i     = 1'b0;
        cfg_all_ch_i    = all_ch;
        cfg_ch_sel_i    = sel;
        cfg_skip_i      = CNT_W'(skip);
        cfg_pairs_i     = CNT_W'(pairs);
        @(negedge clk_rwds);
        resetReadModule = 1'b0;
    endtask

    initial begin
        resetReadModule = 1'b1;
        cfg_all_ch_i = 1'b0; cfg_ch_sel_i = 1'b0; cfg_skip_i = '0; cfg_pairs_i = '0;
        ddr_valid_i = 1'b0; ddr_pair_i = '0; fifo_ready_i = 1'b1;

        // Reset state
        do_reset(1'b0, 1'b0, 0, 4);
        chk("rst_valid", 64'(valid_o), 64'h0);
        chk("rst_word", 64'(word_o), 64'h0);
        chk("rst_strb", 64'(strb_o), 64'h0);
        chk("rst_last", 64'(last_o), 64'h0);
        chk("rst_ovf", 64'(overflow_o), 64'h0);
        chk("rst_done", 64'(done_o), 64'h0);

        // Single lane 0, four pairs -> two full words
        step(1'b1, 32'h0000_1122);
        step(1'b1, 32'h0000_3344);
        chk("t1_novalid", 64'(valid_o), 64'h0);
        step(1'b1, 32'h0000_5566);
        chk("t1_w0_valid", 64'(valid_o), 64'h1);
        chk("t1_w0_word", 64'(word_o), 64'h3344_1122);
        chk("t1_w0_strb", 64'(strb_o), 64'hF);
        chk("t1_w0_last", 64'(last_o), 64'h0);
        step(1'b1, 32'h0000_7788);
        chk("t1_pulse", 64'(valid_o), 64'h0);
        step(1'b0, 32'h0);
        chk("t1_w1_valid", 64'(valid_o), 64'h1);
        chk("t1_w1_word", 64'(word_o), 64'h7788_5566);
        chk("t1_w1_strb", 64'(strb_o), 64'hF);
        chk("t1_w1_last", 64'(last_o), 64'h1);
        chk("t1_done", 64'(done_o), 64'h1);
        step(1'b0, 32'h0);
        chk("t1_after_valid", 64'(valid_o), 64'h0);
        chk("t1_after_done", 64'(done_o), 64'h1);

        // Three pairs -> partial final word
        do_reset(1'b0, 1'b0, 0, 3);
        step(1'b1, 32'h0000_1122);
        step(1'b1, 32'h0000_3344);
        step(1'b1, 32'h0000_5566);
        chk("t2_w0_word", 64'(word_o), 64'h3344_1122);
        step(1'b0, 32'h0);
        chk("t2_w1_valid", 64'(valid_o), 64'h1);
        chk("t2_w1_word", 64'(word_o), 64'h0000_5566);
        chk("t2_w1_strb", 64'(strb_o), 64'h3);
        chk("t2_w1_last", 64'(last_o), 64'h1);
        chk("t2_done", 64'(done_o), 64'h1);

        // All lanes, skip two, deliver two
        do_reset(1'b1, 1'b0, 2, 2);
        step(1'b1, 32'hAAAA_BBBB);
        step(1'b1, 32'hCCCC_DDDD);
        step(1'b1, 32'h0102_0304);
        chk("t3_skip_novalid", 64'(valid_o), 64'h0);
        step(1'b1, 32'h0506_0708);
        chk("t3_w0_valid", 64'(valid_o), 64'h1);
        chk("t3_w0_word", 64'(word_o), 64'h0102_0304);
        chk("t3_w0_strb", 64'(strb_o), 64'hF);
        chk("t3_w0_last", 64'(last_o), 64'h0);
        step(1'b0, 32'h0);
        chk("t3_w1_word", 64'(word_o), 64'h0506_0708);
        chk("t3_w1_last", 64'(last_o), 64'h1);
        chk("t3_done", 64'(done_o), 64'h1);

        // Lane 1 selected
        do_reset(1'b0, 1'b1, 0, 2);
        step(1'b1, 32'h1122_9999);
        step(1'b1, 32'h3344_8888);
        step(1'b0, 32'h0);
        chk("t4_word", 64'(word_o), 64'h3344_1122);
        chk("t4_last", 64'(last_o), 64'h1);

        // pairs=0 -> nothing emitted, done after first pair
        do_reset(1'b0, 1'b0, 0, 0);
        step(1'b1, 32'h0000_1234);
        step(1'b0, 32'h0);
        chk("t5_valid", 64'(valid_o), 64'h0);
        chk("t5_done", 64'(done_o), 64'h1);

        // Overflow: FIFO not ready at the first emit
        do_reset(1'b0, 1'b0, 0, 4);
        fifo_ready_i = 1'b0;
        step(1'b1, 32'h0000_1122);
        step(1'b1, 32'h0000_3344);
        step(1'b1, 32'h0000_5566);
        chk("t6_valid", 64'(valid_o), 64'h1);
        chk("t6_ovf_pre", 64'(overflow_o), 64'h0);
        step(1'b1, 32'h0000_7788);
        fifo_ready_i = 1'b1;
        chk("t6_ovf_set", 64'(overflow_o), 64'h1);
        chk("t6_word_held", 64'(word_o), 64'h3344_1122);
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        chk("t6_ovf_sticky", 64'(overflow_o), 64'h1);
        chk("t6_done", 64'(done_o), 64'h1);
        do_reset(1'b0, 1'b0, 0, 4);
        chk("t6_ovf_clr", 64'(overflow_o), 64'h0);

        // Reset mid-burst discards the partial word
        step(1'b1, 32'h0000_DEAD);
        do_reset(1'b0, 1'b0, 0, 4);
        chk("t7_valid_rst", 64'(valid_o), 64'h0);
        step(1'b1, 32'h0000_1122);
        step(1'b1, 32'h0000_3344);
        step(1'b0, 32'h0);
        chk("t7_valid", 64'(valid_o), 64'h1);
        chk("t7_word", 64'(word_o), 64'h3344_1122);
        chk("t7_done", 64'(done_o), 64'h0);

`ifdef HYPER_RX_ERR_EN
        // Extra pairs after DONE with skip=1, pairs=2
        do_reset(1'b0, 1'b0, 1, 2);
        chk("t8_err_rst", 64'(err_extra_o), 64'h0);
        step(1'b1, 32'h0000_FFFF);
        step(1'b1, 32'h0000_1122);
        step(1'b1, 32'h0000_3344);
        step(1'b1, 32'h0000_AAAA);
        chk("t8_word", 64'(word_o), 64'h3344_1122);
        chk("t8_err_pre", 64'(err_extra_o), 64'h0);
        step(1'b1, 32'h0000_BBBB);
        step(1'b0, 32'h0);
        chk("t8_err", 64'(err_extra_o), 64'h1);
        chk("t8_cnt", 64'(pair_cnt_o), 64'd5);
        chk("t8_valid", 64'(valid_o), 64'h0);
        chk("t8_word_held", 64'(word_o), 64'h3344_1122);
        chk("t8_done", 64'(done_o), 64'h1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
